rs_flag_bank: RTL
=================

// Module: rs_flag_bank
// PURPOSE
//   Parametrised bank of N set/reset status flags for the UART (TXRDY, RXRDY, errors).
//   Provides optional edge-qualified set/reset inputs, a compile-time simultaneous-event priority,
//   and a masked clear-on-read strobe.
//   Adds a masked, registered interrupt output and optional sticky overrun tracking with a
//   saturating counter.
//   Sits between the UART datapath event pulses and the CPU-visible status/interrupt registers.
// PARAMETERS
//   N            8  number of flag channels (1..32)
//   SET_DOMINANT 1  1: set wins on a simultaneous set+reset/clear; 0: reset/clear wins
//   EDGE         1  1: s/r act on rising edge only; 0: s/r act while level-high
//   CNT_W        4  width of ovr_cnt, saturating
// PORTS
//   clk       in   1      clock, rising edge
//   reset     in   1      asynchronous, active-high; clears all state
//   s         in   N      per-channel set request
//   r         in   N      per-channel reset request
//   rd_clr    in   1      status-read strobe; clears the flags selected by clr_mask
//   clr_mask  in   N      channels cleared by rd_clr
//   ie        in   N      per-channel interrupt enable
//   cnt_clr   in   1      synchronous clear of ovr_cnt
//   q         out  N      flag state
//   ovr       out  N      sticky per-channel overrun
//   ovr_cnt   out  CNT_W  total overrun events, saturating
//   irq       out  1      registered interrupt
// BEHAVIOUR
//   Reset: q, ovr, ovr_cnt, irq, s_q and r_q (previous-cycle copies of s, r) all 0, asynchronously.
//   Events, per channel i, evaluated every cycle:
//     EDGE=1: set_evt = s & ~s_q, rst_evt = r & ~r_q.
//     EDGE=0: set_evt = s, rst_evt = r.
//     clr_evt = rd_clr & clr_mask[i]; kill = rst_evt | clr_evt.
//   Next flag value:
//     set_evt & kill  -> SET_DOMINANT ? 1 : 0.
//     set_evt only    -> 1.
//     kill only       -> 0.
//     neither         -> hold.
//     Never X/Z.
//   Latency: q updates on the same rising edge that samples the event, i.e. one cycle.
//   EDGE=1 with s held high after reset release: one set event on the first edge, then none
//   until s falls and rises again.
//   irq <= |((q_next | ovr_next) & ie); irq rises on the same edge as the flag.
//   irq uses ovr_next only when overrun tracking is compiled in.
//   rd_clr with clr_mask=0 has no effect. Writes to ie take effect on the next edge.
// CONFIGURATION
//   Macro RS_FLAG_OVR_EN.
//   Defined:
//     - ovf_evt[i] = set_evt[i] & q[i], using the pre-edge q.
//     - ovr[i] sets on ovf_evt and clears on clr_evt; ovf_evt wins if both occur in one cycle.
//     - ovr_cnt += popcount(ovf_evt), saturating at 2^CNT_W-1; this holds at saturation.
//     - cnt_clr zeroes ovr_cnt; cnt_clr has priority over increments in the same cycle.
//   Undefined: ovr and ovr_cnt are tied to 0, irq ignores ovr, and the ports remain present.
// TESTING (N=8, CNT_W=4, EDGE=1 unless noted)
//   1. reset=1 with s=FF, then release, s held FF for 5 cycles
//      -> q=00 during reset; q=FF after the first edge; ovr=00 (no repeat events).
//   2. s=01 pulse, then r=01 pulse two cycles later -> q=01, then q=00.
//      EDGE=0 with s=01 held -> q stays 01.
//   3. s[2] and r[2] rise in the same cycle -> SET_DOMINANT=1: q[2]=1; SET_DOMINANT=0: q[2]=0.
//   4. q=08, ie=08 -> irq=1. rd_clr=1 with clr_mask=08 -> q=00 and irq=0 on the next edge.
//      clr_mask=00 -> no change.
//   5. RS_FLAG_OVR_EN, q=03, pulse s=03 -> ovr=03, ovr_cnt=2.
//      Then 7 more pulses -> ovr_cnt=15, saturated. cnt_clr -> ovr_cnt=0.
//   6. RS_FLAG_OVR_EN undefined, stimulus of 5 -> ovr=00, ovr_cnt=0. Assert reset mid-sequence
//      -> all outputs 0 immediately.

Source files
------------

// File: rtl/rs_flag_bank.sv
// Bank of N set/reset status flags with edge/level event qualification, masked clear-on-read
// and a registered interrupt. Sticky overrun tracking is compiled in by defining RS_FLAG_OVR_EN.
module rs_flag_bank #(
  parameter int N            = 8,
  parameter int SET_DOMINANT = 1,
  parameter int EDGE         = 1,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     s,
  input  logic [N-1:0]     r,
  input  logic             rd_clr,
  input  logic [N-1:0]     clr_mask,
  input  logic [N-1:0]     ie,
  input  logic             cnt_clr,
  output logic [N-1:0]     q,
  output logic [N-1:0]     ovr,
  output logic [CNT_W-1:0] ovr_cnt,
  output logic             irq
);

  logic [N-1:0]     s_q, r_q;
  logic [N-1:0]     set_evt, rst_evt, clr_evt, kill;
  logic [N-1:0]     q_next, ovr_next;
  logic [CNT_W-1:0] cnt_next;
  logic             irq_next;

  always_comb begin
    set_evt = (EDGE != 0) ? (s & ~s_q) : s;
    rst_evt = (EDGE != 0) ? (r & ~r_q) : r;
    clr_evt = {N{rd_clr}} & clr_mask;
    kill    = rst_evt | clr_evt;
    // Simultaneous set+kill resolves toward the dominant side; otherwise set -> 1, kill -> 0.
    if (SET_DOMINANT != 0)
      q_next = set_evt | (q & ~kill);
    else
      q_next = (set_evt | q) & ~kill;
  end

`ifdef RS_FLAG_OVR_EN
  // Sum width leaves room for popcount of up to 32 channels on top of the counter.
  localparam int SW = CNT_W + 6;
  localparam logic [SW-1:0] CNT_MAX = SW'((64'd1 << CNT_W) - 64'd1);

  logic [N-1:0]  ovf_evt;
  logic [SW-1:0] pop, sum;

  always_comb begin
    ovf_evt  = set_evt & q;
    ovr_next = ovf_evt | (ovr & ~clr_evt);
    pop      = '0;
    for (int i = 0; i < N; i++) pop = pop + SW'(ovf_evt[i]);
    sum      = SW'(ovr_cnt) + pop;
    if (cnt_clr)
      cnt_next = '0;
    else if (sum > CNT_MAX)
      cnt_next = CNT_MAX[CNT_W-1:0];
    else
      cnt_next = sum[CNT_W-1:0];
    irq_next = |((q_next | ovr_next) & ie);
  end
`else
  logic unused_cnt_clr;

  always_comb begin
    unused_cnt_clr = cnt_clr;
    ovr_next       = '0;
    cnt_next       = '0;
    irq_next       = |(q_next & ie);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q     <= '0;
      r_q     <= '0;
      q       <= '0;
      ovr     <= '0;
      ovr_cnt <= '0;
      irq     <= 1'b0;
    end else begin
      s_q     <= s;
      r_q     <= r;
      q       <= q_next;
      ovr     <= ovr_next;
      ovr_cnt <= cnt_next;
      irq     <= irq_next;
    end
  end

endmodule
